// File: rtl/led_pkg.sv
// Shared types for the LED pattern sequencer: mode codes, entry patterns, mode ordering.
// LED_BREATHE_EN adds the BREATHE mode after RUN_R.
package led_pkg;

  typedef enum logic [2:0] {
    M_OFF     = 3'b000,
    M_BLINK   = 3'b001,
    M_RUN_L   = 3'b010,
    M_RUN_R   = 3'b011,
    M_BREATHE = 3'b100
  } mode_t;

  // Entry patterns are described by kind so they scale with the LED bank width
  typedef enum logic [1:0] {
    PAT_ZERO,
    PAT_ONES,
    PAT_LSB,
    PAT_MSB
  } entry_pat_t;

`ifdef LED_BREATHE_EN
  localparam mode_t MODE_LAST = M_BREATHE;
`else
  localparam mode_t MODE_LAST = M_RUN_R;
`endif

  function automatic mode_t next_mode(input mode_t m);
    mode_t r;
    if (m == MODE_LAST) begin
      r = M_OFF;
    end else begin
      case (m)
        M_OFF:   r = M_BLINK;
        M_BLINK: r = M_RUN_L;
        M_RUN_L: r = M_RUN_R;
        M_RUN_R: r = M_BREATHE;
        default: r = M_OFF;
      endcase
    end
    return r;
  endfunction

  function automatic entry_pat_t entry_pat(input mode_t m);
    entry_pat_t p;
    case (m)
      M_BLINK: p = PAT_ONES;
      M_RUN_L: p = PAT_LSB;
      M_RUN_R: p = PAT_MSB;
      default: p = PAT_ZERO;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Millisecond prescaler: one-cycle ms_tick on the terminal count, synchronous clear, enable freezes it.
module led_tick_gen #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic ms_tick
);

  localparam int TERM = CLK_FREQ_HZ / 1000 - 1;
  localparam int CW   = (TERM > 0) ? $clog2(TERM + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign ms_tick = en && (cnt_q == CW'(TERM));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)          cnt_d = '0;
    else if (ms_tick) cnt_d = '0;
    else if (en)      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: mode FSM, ms-based step scheduler and pattern datapath.
// LED_BREATHE_EN enables the BREATHE mode with a 4-bit PWM duty ramp.
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int LED_W       = 4,
  parameter int SM_W        = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_next,
  input  logic             pause_tgl,
  input  logic [SM_W-1:0]  step_ms,
  output logic [LED_W-1:0] led,
  output logic [2:0]       mode,
  output logic             paused,
  output logic             step_pulse
);

  mode_t            mode_q, mode_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             paused_q, paused_d;
  logic             step_pulse_q, step_pulse_d;
  logic [SM_W-1:0]  step_cnt_q, step_cnt_d;
  logic [SM_W-1:0]  step_lat_q, step_lat_d;
  logic [SM_W-1:0]  lat_new;
  logic             ms_tick, step_term, step_fire;
  logic [LED_W-1:0] breathe_led;

  function automatic logic [LED_W-1:0] entry_led(input mode_t m);
    logic [LED_W-1:0] v;
    case (entry_pat(m))
      PAT_ONES: v = '1;
      PAT_LSB:  v = LED_W'(1);
      PAT_MSB:  v = {1'b1, {(LED_W-1){1'b0}}};
      default:  v = '0;
    endcase
    return v;
  endfunction

  led_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (mode_next),
    .en      (!paused_q),
    .ms_tick (ms_tick)
  );

  assign lat_new   = (step_ms == '0) ? SM_W'(1) : step_ms;
  assign step_term = ms_tick && (step_cnt_q == step_lat_q - SM_W'(1));
  // A mode change on the terminal cycle swallows that step
  assign step_fire = step_term && !mode_next;

`ifdef LED_BREATHE_EN
  localparam int PWM_DIV = (CLK_FREQ_HZ / 1000 / 16 > 0) ? CLK_FREQ_HZ / 1000 / 16 : 1;
  localparam int DW      = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [DW-1:0] pdiv_q;
  logic [3:0]    pwm_q, duty_q;
  logic          up_q, pwm_adv;

  assign pwm_adv     = !paused_q && (pdiv_q == DW'(PWM_DIV - 1));
  assign breathe_led = {LED_W{pwm_q < duty_q}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pdiv_q <= '0;
      pwm_q  <= '0;
      duty_q <= '0;
      up_q   <= 1'b1;
    end else begin
      if (!paused_q) pdiv_q <= pwm_adv ? '0 : pdiv_q + DW'(1);
      if (pwm_adv)   pwm_q  <= pwm_q + 4'd1;
      if (mode_next) begin
        duty_q <= '0;
        up_q   <= 1'b1;
      end else if (step_fire && mode_q == M_BREATHE) begin
        if (up_q) begin
          duty_q <= duty_q + 4'd1;
          if (duty_q == 4'd14) up_q <= 1'b0;
        end else begin
          duty_q <= duty_q - 4'd1;
          if (duty_q == 4'd1) up_q <= 1'b1;
        end
      end
    end
  end
`else
  assign breathe_led = '0;
`endif

  always_comb begin
    mode_d       = mode_q;
    led_d        = led_q;
    paused_d     = paused_q;
    step_pulse_d = 1'b0;
    step_cnt_d   = step_cnt_q;
    step_lat_d   = step_lat_q;
    if (mode_next) begin
      mode_d     = next_mode(mode_q);
      led_d      = entry_led(next_mode(mode_q));
      paused_d   = 1'b0;
      step_cnt_d = '0;
      step_lat_d = lat_new;
    end else begin
      if (pause_tgl) paused_d = !paused_q;
      if (ms_tick) begin
        if (step_term) begin
          step_cnt_d   = '0;
          step_lat_d   = lat_new;
          step_pulse_d = 1'b1;
          case (mode_q)
            M_BLINK: led_d = ~led_q;
            M_RUN_L: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
            M_RUN_R: led_d = {led_q[0], led_q[LED_W-1:1]};
            default: led_d = led_q;
          endcase
        end else begin
          step_cnt_d = step_cnt_q + SM_W'(1);
        end
      end
      if (mode_q == M_BREATHE && !paused_q) led_d = breathe_led;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q       <= M_OFF;
      led_q        <= '0;
      paused_q     <= 1'b0;
      step_pulse_q <= 1'b0;
      step_cnt_q   <= '0;
      step_lat_q   <= SM_W'(1);
    end else begin
      mode_q       <= mode_d;
      led_q        <= led_d;
      paused_q     <= paused_d;
      step_pulse_q <= step_pulse_d;
      step_cnt_q   <= step_cnt_d;
      step_lat_q   <= step_lat_d;
    end
  end

  assign led        = led_q;
  assign mode       = mode_q;
  assign paused     = paused_q;
  assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl at 4 clk/ms; inputs driven and outputs sampled on falling edges.
module tb_led_pattern_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_next, pause_tgl;
  logic [9:0] step_ms;
  logic [3:0] led;
  logic [2:0] mode;
  logic       paused, step_pulse;

  int checks = 0;
  int errors = 0;

  led_pattern_ctrl #(.CLK_FREQ_HZ(4000), .LED_W(4), .SM_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_next  (mode_next),
    .pause_tgl  (pause_tgl),
    .step_ms    (step_ms),
    .led        (led),
    .mode       (mode),
    .paused     (paused),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_mode();
    mode_next = 1'b1;
    @(negedge clk);
    mode_next = 1'b0;
  endtask

  task automatic pulse_pause();
    pause_tgl = 1'b1;
    @(negedge clk);
    pause_tgl = 1'b0;
  endtask

  initial begin
    logic seen;
    rst = 1'b1; mode_next = 1'b0; pause_tgl = 1'b0; step_ms = 10'd2;
    wait_n(2);
    check("rst_led", led, 4'b0000);
    check("rst_mode", mode, 3'b000);
    check("rst_paused", paused, 1'b0);
    check("rst_pulse", step_pulse, 1'b0);
    rst = 1'b0;

    // BLINK: toggles every 8 clk
    pulse_mode();
    check("blink_mode", mode, 3'b001);
    check("blink_entry", led, 4'b1111);
    wait_n(7);
    check("blink_pre_led", led, 4'b1111);
    check("blink_pre_pulse", step_pulse, 1'b0);
    wait_n(1);
    check("blink_s1_led", led, 4'b0000);
    check("blink_s1_pulse", step_pulse, 1'b1);
    wait_n(1);
    check("blink_pulse_1cyc", step_pulse, 1'b0);
    wait_n(7);
    check("blink_s2_led", led, 4'b1111);

    // RUN_L rotation
    pulse_mode();
    check("runl_mode", mode, 3'b010);
    check("runl_entry", led, 4'b0001);
    wait_n(8); check("runl_s1", led, 4'b0010);
    wait_n(8); check("runl_s2", led, 4'b0100);
    wait_n(8); check("runl_s3", led, 4'b1000);
    wait_n(8); check("runl_wrap", led, 4'b0001);

    // RUN_R with pause: one running clk before freeze, seven after release
    pulse_mode();
    check("runr_mode", mode, 3'b011);
    check("runr_entry", led, 4'b1000);
    pulse_pause();
    check("pause_set", paused, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (step_pulse) seen = 1'b1;
    end
    check("pause_led_held", led, 4'b1000);
    check("pause_no_pulse", seen, 1'b0);
    check("pause_mode_read", mode, 3'b011);
    pulse_pause();
    check("unpause", paused, 1'b0);
    wait_n(6);
    check("unpause_pre", led, 4'b1000);
    wait_n(1);
    check("unpause_step", led, 4'b0100);
    check("unpause_pulse", step_pulse, 1'b1);

    // RUN_R -> OFF -> BLINK, pause, then mode_next+pause_tgl together
    pulse_mode();
    check("wrap_off", mode, 3'b000);
    check("off_led", led, 4'b0000);
    pulse_mode();
    pulse_pause();
    check("blink_paused", paused, 1'b1);
    mode_next = 1'b1; pause_tgl = 1'b1;
    @(negedge clk);
    mode_next = 1'b0; pause_tgl = 1'b0;
    check("both_mode", mode, 3'b010);
    check("both_paused", paused, 1'b0);
    check("both_led", led, 4'b0001);

    // step_ms = 0 behaves as 1 ms
    step_ms = 10'd0;
    pulse_mode();
    check("sm0_entry", led, 4'b1000);
    wait_n(4); check("sm0_s1", led, 4'b0100);
    wait_n(4); check("sm0_s2", led, 4'b0010);

    // step_ms change mid-step applies at the next boundary
    step_ms = 10'd2;
    pulse_mode();
    pulse_mode();
    check("sm_blink_entry", led, 4'b1111);
    wait_n(2);
    step_ms = 10'd5;
    wait_n(6);
    check("sm_old_period", led, 4'b0000);
    wait_n(19);
    check("sm_new_pre", led, 4'b0000);
    wait_n(1);
    check("sm_new_step", led, 4'b1111);

    // mode_next on the step terminal cycle: mode change wins, no step
    wait_n(19);
    mode_next = 1'b1;
    @(negedge clk);
    mode_next = 1'b0;
    check("term_mode", mode, 3'b010);
    check("term_led", led, 4'b0001);
    check("term_no_pulse", step_pulse, 1'b0);

    // Async reset mid-pattern, then OFF still pulses with reset latency of 1 ms
    wait_n(3);
    #2 rst = 1'b1;
    #1;
    check("arst_led", led, 4'b0000);
    check("arst_mode", mode, 3'b000);
    check("arst_paused", paused, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wait_n(3);
    check("off_pre_pulse", step_pulse, 1'b0);
    wait_n(1);
    check("off_pulse", step_pulse, 1'b1);
    check("off_led_const", led, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
